// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, controller state type and rotate helper
package sha256_pkg;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA256_WORD = 32;
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
  localparam logic [255:0] SHA256_H_0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
endpackage

// File: rtl/sha256_Krom.sv
// sha256_Krom: round constant ROM with one cycle of read latency
module sha256_Krom
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic [5:0]  addr,
  output logic [31:0] k
);
  // registered read
  always_ff @(posedge clk) k <= SHA256_K[addr];
endmodule

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round over {a..h}
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);
  logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
  assign {a, b, c, d, e, f, g, h} = state_in;
  assign t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
  assign t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_s0.sv
// sha256_s0: message schedule small sigma-0
module sha256_s0
  import sha256_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
endmodule

// File: rtl/sha256_s1.sv
// sha256_s1: message schedule small sigma-1
module sha256_s1
  import sha256_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
endmodule

// File: rtl/sha256_wsched.sv
// sha256_wsched: 16-word message schedule shift register, sched[0] is Wj
module sha256_wsched (
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output logic [31:0]  w
);
  logic [31:0] sched [16];
  logic [31:0] s0_y, s1_y, w_new;
  sha256_s0 u_s0 (.x(sched[1]), .y(s0_y));
  sha256_s1 u_s1 (.x(sched[14]), .y(s1_y));
  assign w_new = s1_y + sched[9] + s0_y + sched[0];
  assign w = sched[0];
  // load M0..M15 on accept, otherwise shift in W(j+16) each round
  always_ff @(posedge clk)
    if (load) for (int i = 0; i < 16; i++) sched[i] <= block[511 - 32*i -: 32];
    else if (shift) begin
      for (int i = 0; i < 15; i++) sched[i] <= sched[i + 1];
      sched[15] <= w_new;
    end
endmodule

// File: rtl/sha256_compress_ctrl.sv
// sha256_compress_ctrl: one-block SHA-256 compression sequencer; SHA256_CHAIN_EN enables multi-block chaining via in_first
module sha256_compress_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
`ifdef SHA256_CHAIN_EN
  input  logic         in_first,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);
  state_t state, state_nx;
  logic [5:0] j, k_addr;
  logic [SHA256_WORD-1:0] k, w;
  logic [255:0] h_reg, work, round_out, start_iv, base, h_sum;
  logic accept, last;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_digest = h_reg;
  assign accept = in_valid & in_ready;
  assign last = j == 6'(SHA256_ROUNDS - 1);
`ifdef SHA256_CHAIN_EN
  logic from_h0;
  assign start_iv = in_first ? SHA256_H_0 : h_reg;
  assign base = from_h0 ? SHA256_H_0 : h_reg;
  // remember whether this block restarts the message, so the final add uses the right IV
  always_ff @(posedge clk) if (accept) from_h0 <= in_first;
`else
  assign start_iv = SHA256_H_0;
  assign base = SHA256_H_0;
`endif
  for (genvar i = 0; i < 8; i++) begin : g_add
    assign h_sum[32*i +: 32] = base[32*i +: 32] + work[32*i +: 32];
  end
  sha256_Krom u_krom (.clk(clk), .addr(k_addr), .k(k));
  sha256_wsched u_wsched (.clk(clk), .load(accept), .shift(state == ROUND), .block(in_block), .w(w));
  sha256_round u_round (.state_in(work), .k(k), .w(w), .state_out(round_out));
  // next state and Krom address; LOAD pre-reads K0 to hide ROM latency
  always_comb begin
    state_nx = state;
    k_addr = '0;
    case (state)
      IDLE: state_nx = accept ? LOAD : IDLE;
      LOAD: state_nx = ROUND;
      ROUND: begin
        k_addr = j + 6'd1;
        state_nx = last ? FINAL : ROUND;
      end
      FINAL: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // control state, round counter and chaining value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      j <= '0;
      h_reg <= SHA256_H_0;
    end else begin
      state <= state_nx;
      j <= state == ROUND ? j + 6'd1 : 6'd0;
      if (state == FINAL) h_reg <= h_sum;
    end
  // working variables a..h
  always_ff @(posedge clk)
    if (accept) work <= start_iv;
    else if (state == ROUND) work <= round_out;
endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// tb_sha256_compress_ctrl: self-checking bench with a behavioural SHA-256 model and per-cycle compare
module tb_sha256_compress_ctrl;
  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [511:0] in_block = '0;
  logic [255:0] out_digest;
`ifdef SHA256_CHAIN_EN
  logic in_first = 1;
`endif
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;

  sha256_compress_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
`ifdef SHA256_CHAIN_EN
    .in_first(in_first),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // plain textbook SHA-256 compression of one block from a given IV
  function automatic logic [255:0] sha_blk(input logic [511:0] blk, input logic [255:0] iv);
    logic [31:0] wv [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) wv[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      wv[t] = (ror(wv[t-2], 17) ^ ror(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
            + (ror(wv[t-15], 7) ^ ror(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
    for (int i = 0; i < 8; i++) v[i] = iv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wv[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = iv[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // cycle-level model: idle / busy counting edges since accept / done
  logic m_busy, m_done;
  int m_cnt;
  logic [255:0] m_h, m_dig, m_iv;
`ifdef SHA256_CHAIN_EN
  assign m_iv = in_first ? H0 : m_h;
`else
  assign m_iv = H0;
`endif
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 0;
      m_done <= 0;
      m_cnt <= 0;
      m_h <= H0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1;
        m_cnt <= 0;
        m_dig <= sha_blk(in_block, m_iv);
      end
    end else if (m_done) begin
      if (out_ready) begin
        m_busy <= 0;
        m_done <= 0;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 65) begin
        m_done <= 1;
        m_h <= m_dig;
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_done);
      chk("digest_reg", out_digest, m_h);
    end

  task automatic send(input logic [511:0] blk, input logic first);
    for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end
    in_valid = 1;
    in_block = blk;
`ifdef SHA256_CHAIN_EN
    in_first = first;
`else
    if (first) in_block = blk;
`endif
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done(input string name, input logic [255:0] exp);
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: out_valid got 0 want 1", name);
    end else begin
      chk({name, "_latency"}, 256'(cyc - acc_cyc), 256'd66);
      chk({name, "_digest"}, out_digest, exp);
    end
  endtask

  task automatic take();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    chk("model_abc", sha_blk(ABC, H0), D_ABC);
    chk("model_empty", sha_blk(EMPTY, H0), D_EMPTY);
    chk("model_two", sha_blk(B2, sha_blk(B1, H0)), D_TWO);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_digest", out_digest, H0);
    send(ABC, 1);
    wait_done("abc", D_ABC);
    take();
    send(EMPTY, 1);
    wait_done("empty", D_EMPTY);
    take();
`ifdef SHA256_CHAIN_EN
    send(B1, 1);
    wait_done("blk1", sha_blk(B1, H0));
    take();
    send(B2, 0);
    wait_done("two", D_TWO);
    take();
    send(ABC, 1);
    wait_done("abc_restart", D_ABC);
    take();
`endif
    send(ABC, 1);
    repeat (10) @(negedge clk);
    in_block = EMPTY;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_done("bp", D_ABC);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_digest", out_digest, D_ABC);
    end
    in_valid = 0;
    take();
    chk("release_idle", in_ready, 1);
    send(EMPTY, 1);
    repeat (31) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_digest", out_digest, H0);
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    send(ABC, 1);
    wait_done("abc_after_rst", D_ABC);
    take();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
